mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Sequences each access over a configurable number of memory cycles and returns read data to the owning port with a one-cycle ready pulse.
- Sits between the pipeline and the unified memory, replacing the separate instruction/data memories in the top-level bench.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter that gives the fetch port and the load/store port turns on one single-ported memory.
// Define ARB_RR_EN to replace fixed data-first priority with round-robin tie breaking.
module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wr,
  output logic [1:0]  m_size,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        owner_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addrQ;
  logic [31:0]      wdataQ;
  logic             wrQ;
  logic [1:0]       sizeQ;
  logic             grantAny;
  logic             grantD;

`ifdef ARB_RR_EN
  logic lastD;
  // On a tie the port that was not served last goes first.
  assign grantD = d_req && (!i_req || !lastD);
`else
  assign grantD = d_req;
`endif
  assign grantAny = d_req || i_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      busy    <= 1'b0;
      owner_d <= 1'b0;
`ifdef ARB_RR_EN
      lastD   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grantAny) begin
            state   <= ACCESS;
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
            owner_d <= grantD;
`ifdef ARB_RR_EN
            lastD   <= grantD;
`endif
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= RESP;
            if (owner_d) begin
              d_rdata <= m_rdata;
              d_ready <= 1'b1;
            end else begin
              i_rdata <= m_rdata;
              i_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // Requests are deliberately not sampled here so a dropped req is never re-granted.
          state   <= IDLE;
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields are captured once at grant; only the FSM state needs reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && grantAny) begin
      if (grantD) begin
        addrQ  <= d_addr;
        wdataQ <= d_wdata;
        wrQ    <= d_wr;
        sizeQ  <= d_size;
      end else begin
        addrQ  <= i_addr;
        wdataQ <= '0;
        wrQ    <= 1'b0;
        sizeQ  <= 2'b10;
      end
    end
  end

  // The write enable is confined to the final access cycle so each store commits once.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_size  = '0;
    m_wr    = 1'b0;
    if (state == ACCESS) begin
      m_addr  = addrQ;
      m_wdata = wdataQ;
      m_size  = sizeQ;
      m_wr    = wrQ && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a LATENCY=2 instance on a small memory model, plus a LATENCY=1 instance.
module tb_mem_arbiter;

  localparam int LAT2 = 2;

  typedef struct {
    bit          isD;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // LATENCY=2 instance signals
  logic        i_req2, i_ready2, d_req2, d_wr2, d_ready2, m_wr2, busy2, owner_d2;
  logic [31:0] i_addr2, i_rdata2, d_addr2, d_wdata2, d_rdata2, m_addr2, m_wdata2, m_rdata2;
  logic [1:0]  d_size2, m_size2;

  // LATENCY=1 instance signals
  logic        i_req1, i_ready1, d_req1, d_wr1, d_ready1, m_wr1, busy1, owner_d1;
  logic [31:0] i_addr1, i_rdata1, d_addr1, d_wdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic [1:0]  d_size1, m_size1;

  mem_arbiter #(.LATENCY(2), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset),
    .i_req(i_req2), .i_addr(i_addr2), .i_rdata(i_rdata2), .i_ready(i_ready2),
    .d_req(d_req2), .d_addr(d_addr2), .d_wdata(d_wdata2), .d_wr(d_wr2), .d_size(d_size2),
    .d_rdata(d_rdata2), .d_ready(d_ready2),
    .m_addr(m_addr2), .m_wdata(m_wdata2), .m_wr(m_wr2), .m_size(m_size2), .m_rdata(m_rdata2),
    .busy(busy2), .owner_d(owner_d2)
  );

  mem_arbiter #(.LATENCY(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ready(i_ready1),
    .d_req(d_req1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_wr(d_wr1), .d_size(d_size1),
    .d_rdata(d_rdata1), .d_ready(d_ready1),
    .m_addr(m_addr1), .m_wdata(m_wdata1), .m_wr(m_wr1), .m_size(m_size1), .m_rdata(m_rdata1),
    .busy(busy1), .owner_d(owner_d1)
  );

  // Memory model: fixed initial contents overlaid by whatever the LATENCY=2 instance stores.
  logic [31:0] memArr [0:255];
  bit          memWritten [0:255];

  function automatic logic [31:0] initWord(input logic [7:0] idx);
    case (idx)
      8'd4:    return 32'h8C220004;
      8'd8:    return 32'h20202020;
      8'd9:    return 32'h24242424;
      8'd10:   return 32'h28282828;
      8'd12:   return 32'h30303030;
      8'd64:   return 32'h0000ABCD;
      8'd128:  return 32'h11112222;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (m_wr2) begin
      memArr[m_addr2[9:2]]     <= m_wdata2;
      memWritten[m_addr2[9:2]] <= 1'b1;
    end
  end

  assign m_rdata2 = memWritten[m_addr2[9:2]] ? memArr[m_addr2[9:2]] : initWord(m_addr2[9:2]);
  assign m_rdata1 = memWritten[m_addr1[9:2]] ? memArr[m_addr1[9:2]] : initWord(m_addr1[9:2]);

  int   nChecks = 0;
  int   nPass   = 0;
  int   wrCount = 0;
  exp_t sb2[$];
  exp_t sb1[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic void failNow(input string name, input string what);
    nChecks++;
    $display("FAIL %s: %s", name, what);
  endfunction

  function automatic void push2(input bit isD, input bit chk, input logic [31:0] data);
    exp_t e;
    e.isD = isD; e.chk = chk; e.data = data;
    sb2.push_back(e);
  endfunction

  function automatic void push1(input logic [31:0] data);
    exp_t e;
    e.isD = 1'b0; e.chk = 1'b1; e.data = data;
    sb1.push_back(e);
  endfunction

  // Monitor for the LATENCY=2 instance: every ready pulse must match the next expected response.
  always @(negedge clk) begin
    if (m_wr2) wrCount++;
    if (!reset && (i_ready2 || d_ready2)) begin
      if (sb2.size() == 0) begin
        failNow("sb2_unexpected_ready", $sformatf("i_ready=%0b d_ready=%0b with nothing pending", i_ready2, d_ready2));
      end else begin
        exp_t e;
        e = sb2.pop_front();
        check("sb2_d_ready", d_ready2, e.isD);
        check("sb2_i_ready", i_ready2, !e.isD);
        if (e.chk) check(e.isD ? "sb2_d_rdata" : "sb2_i_rdata", e.isD ? d_rdata2 : i_rdata2, e.data);
      end
    end
  end

  // Monitor for the LATENCY=1 instance, which only ever serves fetches.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_wr1) failNow("sb1_m_wr", "write enable asserted by fetch-only instance");
      if (d_ready1) failNow("sb1_d_ready", "data ready pulsed with no data request");
      if (i_ready1) begin
        if (sb1.size() == 0) begin
          failNow("sb1_unexpected_ready", "i_ready with nothing pending");
        end else begin
          exp_t e;
          e = sb1.pop_front();
          check("sb1_i_rdata", i_rdata1, e.data);
          check("sb1_busy", busy1, 1'b1);
          check("sb1_owner_d", owner_d1, 1'b0);
        end
      end
    end
  end

  // One complete access on the LATENCY=2 instance, held until ready and dropped on it.
  task automatic access2(input bit isD, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit chk, input logic [31:0] expData, input string tag);
    int n;
    int wrAt;
    int wrBefore;
    logic rdy;
    push2(isD, chk, expData);
    @(negedge clk);
    if (isD) begin
      d_req2 = 1'b1; d_addr2 = addr; d_wdata2 = wdata; d_wr2 = wr; d_size2 = size;
    end else begin
      i_req2 = 1'b1; i_addr2 = addr;
    end
    wrBefore = wrCount;
    wrAt = 0;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = isD ? d_ready2 : i_ready2;
      if (!rdy && n <= LAT2) check({tag, "_m_addr"}, m_addr2, addr);
      if (m_wr2 && wrAt == 0) begin
        wrAt = n;
        check({tag, "_m_wdata"}, m_wdata2, wdata);
        check({tag, "_m_size"}, m_size2, size);
      end
    end
    check({tag, "_latency"}, n, LAT2 + 1);
    if (isD) d_req2 = 1'b0; else i_req2 = 1'b0;
    check({tag, "_write_count"}, wrCount - wrBefore, wr ? 1 : 0);
    if (wr) check({tag, "_write_cycle"}, wrAt, LAT2);
  endtask

  task automatic tieA();
    int n, dAt, iAt;
    push2(1'b1, 1'b1, 32'h0000ABCD);
    push2(1'b0, 1'b1, 32'h20202020);
    @(negedge clk);
    d_req2 = 1'b1; d_addr2 = 32'h100; d_wr2 = 1'b0; d_size2 = 2'b10;
    i_req2 = 1'b1; i_addr2 = 32'h20;
    n = 0; dAt = 0; iAt = 0;
    while ((dAt == 0 || iAt == 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("tieA_owner_data", owner_d2, 1'b1);
      if (n == 5) check("tieA_owner_fetch", owner_d2, 1'b0);
      if (d_ready2 && dAt == 0) begin dAt = n; d_req2 = 1'b0; end
      if (i_ready2 && iAt == 0) begin iAt = n; i_req2 = 1'b0; end
    end
    check("tieA_d_latency", dAt, 3);
    check("tieA_i_after_d", iAt - dAt, 4);
  endtask

  // Data re-requests during the idle cycle after its first completion, forming a second tie.
  task automatic tieB();
    int n, d1At, d2At, iAt;
    push2(1'b1, 1'b1, 32'h24242424);
`ifdef ARB_RR_EN
    push2(1'b0, 1'b1, 32'h28282828);
    push2(1'b1, 1'b1, 32'h30303030);
`else
    push2(1'b1, 1'b1, 32'h30303030);
    push2(1'b0, 1'b1, 32'h28282828);
`endif
    @(negedge clk);
    d_req2 = 1'b1; d_addr2 = 32'h24; d_wr2 = 1'b0; d_size2 = 2'b10;
    i_req2 = 1'b1; i_addr2 = 32'h28;
    n = 0; d1At = 0; d2At = 0; iAt = 0;
    while ((d2At == 0 || iAt == 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (d1At != 0 && n == d1At + 1) begin d_req2 = 1'b1; d_addr2 = 32'h30; end
      if (d_ready2) begin
        if (d1At == 0) begin d1At = n; d_req2 = 1'b0; end
        else if (d2At == 0) begin d2At = n; d_req2 = 1'b0; end
      end
      if (i_ready2 && iAt == 0) begin iAt = n; i_req2 = 1'b0; end
    end
    check("tieB_first_d", d1At, 3);
`ifdef ARB_RR_EN
    check("tieB_rr_fetch", iAt, 7);
    check("tieB_rr_data", d2At, 11);
`else
    check("tieB_fixed_data", d2At, 7);
    check("tieB_fixed_fetch", iAt, 11);
`endif
  endtask

  task automatic holdThenDrop();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("idle_busy_%0d", k), busy2, 1'b0);
    end
  endtask

  task automatic abortStore();
    int wrBefore;
    @(negedge clk);
    d_req2 = 1'b1; d_addr2 = 32'h200; d_wdata2 = 32'hBAD0BAD0; d_wr2 = 1'b1; d_size2 = 2'b10;
    wrBefore = wrCount;
    @(negedge clk);
    check("abort_busy_before", busy2, 1'b1);
    check("abort_m_addr_before", m_addr2, 32'h200);
    #2 reset = 1'b1;
    #1;
    check("abort_m_wr", m_wr2, 1'b0);
    check("abort_m_addr", m_addr2, 32'h0);
    check("abort_m_wdata", m_wdata2, 32'h0);
    check("abort_busy", busy2, 1'b0);
    check("abort_owner_d", owner_d2, 1'b0);
    check("abort_d_rdata", d_rdata2, 32'h0);
    check("abort_i_rdata", i_rdata2, 32'h0);
    check("abort_d_ready", d_ready2, 1'b0);
    d_req2 = 1'b0; d_wr2 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_write", wrCount - wrBefore, 0);
    access2(1'b1, 1'b0, 32'h200, 32'h0, 2'b10, 1'b1, 32'h11112222, "abort_reload");
  endtask

  task automatic lat1Fetches();
    int n, k, prev;
    push1(32'h8C220004);
    push1(32'h20202020);
    push1(32'h24242424);
    @(negedge clk);
    i_req1 = 1'b1; i_addr1 = 32'h10;
    n = 0; k = 0; prev = 0;
    while (k < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (i_ready1) begin
        if (k == 0) check("l1_first_latency", n, 2);
        else check($sformatf("l1_spacing_%0d", k), n - prev, 3);
        prev = n;
        k++;
        if (k == 1) i_addr1 = 32'h20;
        else if (k == 2) i_addr1 = 32'h24;
        else i_req1 = 1'b0;
      end
    end
    check("l1_fetch_count", k, 3);
    @(negedge clk);
    check("l1_idle_m_size", m_size1, 2'b00);
    check("l1_idle_m_wdata", m_wdata1, 32'h0);
    check("l1_idle_d_rdata", d_rdata1, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    i_req2 = 1'b0; i_addr2 = '0; d_req2 = 1'b0; d_addr2 = '0; d_wdata2 = '0; d_wr2 = 1'b0; d_size2 = '0;
    i_req1 = 1'b0; i_addr1 = '0; d_req1 = 1'b0; d_addr1 = '0; d_wdata1 = '0; d_wr1 = 1'b0; d_size1 = '0;
    repeat (2) @(negedge clk);
    check("rst_i_ready", i_ready2, 1'b0);
    check("rst_d_ready", d_ready2, 1'b0);
    check("rst_i_rdata", i_rdata2, 32'h0);
    check("rst_d_rdata", d_rdata2, 32'h0);
    check("rst_busy", busy2, 1'b0);
    check("rst_owner_d", owner_d2, 1'b0);
    check("rst_m_addr", m_addr2, 32'h0);
    check("rst_m_wr", m_wr2, 1'b0);
    check("rst_m_size", m_size2, 2'b00);
    reset = 1'b0;

    access2(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b1, 32'h8C220004, "fetch");
    tieA();
    tieB();
    access2(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, "store");
    access2(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b1, 32'hDEADBEEF, "load_back");
    holdThenDrop();
    abortStore();
    lat1Fetches();

    repeat (3) @(negedge clk);
    check("sb2_drained", sb2.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
